single_rom2: RTL and testbench

//   Synchronous 8-bit read-only pixel store for the LCD path: returns one RGB332 pixel per address.

---
 rtl/single_rom2.sv | 82 ++++++++
 tb/tb_single_rom2.sv | 138 +++++++++++++
 2 files changed

// File: rtl/single_rom2.sv
// Computed 640x480 RGB332 test image: colour bars framed by a grey border.
// One registered read per clock, pixel derived arithmetically from the address.
module single_rom2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [31:0] PIXELS = 32'(H_ACTIVE * V_ACTIVE);
    localparam logic [31:0] H_LEN  = 32'(H_ACTIVE);
    localparam logic [31:0] V_LEN  = 32'(V_ACTIVE);
    localparam logic [31:0] BAR_W  = 32'(H_ACTIVE / 8);

    localparam logic [DATA_WIDTH-1:0] C_GREY    = DATA_WIDTH'(8'h92);
    localparam logic [DATA_WIDTH-1:0] C_WHITE   = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] C_YELLOW  = DATA_WIDTH'(8'hFC);
    localparam logic [DATA_WIDTH-1:0] C_CYAN    = DATA_WIDTH'(8'h1F);
    localparam logic [DATA_WIDTH-1:0] C_GREEN   = DATA_WIDTH'(8'h1C);
    localparam logic [DATA_WIDTH-1:0] C_MAGENTA = DATA_WIDTH'(8'hE3);
    localparam logic [DATA_WIDTH-1:0] C_RED     = DATA_WIDTH'(8'hE0);
    localparam logic [DATA_WIDTH-1:0] C_BLUE    = DATA_WIDTH'(8'h03);
    localparam logic [DATA_WIDTH-1:0] C_BLACK   = DATA_WIDTH'(8'h00);

    logic [31:0]           addr_w;
    logic [31:0]           x_pos;
    logic [31:0]           y_pos;
    logic [31:0]           bar_idx;
    logic                  in_range;
    logic                  on_border;
    logic [DATA_WIDTH-1:0] bar_col;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    // Constant divisors; synthesis reduces these to multiply/shift networks.
    always_comb begin
        addr_w    = 32'(addr);
        y_pos     = addr_w / H_LEN;
        x_pos     = addr_w % H_LEN;
        bar_idx   = x_pos / BAR_W;
        in_range  = (addr_w < PIXELS);
        on_border = (x_pos == 32'd0) || (x_pos == H_LEN - 32'd1) ||
                    (y_pos == 32'd0) || (y_pos == V_LEN - 32'd1);
    end

    always_comb begin
        bar_col = C_BLACK;
        case (bar_idx)
            32'd0:   bar_col = C_WHITE;
            32'd1:   bar_col = C_YELLOW;
            32'd2:   bar_col = C_CYAN;
            32'd3:   bar_col = C_GREEN;
            32'd4:   bar_col = C_MAGENTA;
            32'd5:   bar_col = C_RED;
            32'd6:   bar_col = C_BLUE;
            default: bar_col = C_BLACK;
        endcase
    end

    always_comb begin
        q_d = C_BLACK;
        if (in_range) begin
            q_d = on_border ? C_GREY : bar_col;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_single_rom2.sv
// Bench for single_rom2: directed image checks plus random reads
// compared against a coordinate-based model of the test image.
module tb_single_rom2;

    logic        clk;
    logic        rst;
    logic [18:0] addr;
    logic [7:0]  q;

    int n_cmp;
    int n_err;

    single_rom2 dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Image described by its geometry: frame, then eight 80-pixel bars.
    function automatic logic [7:0] ref_pix(input int unsigned a);
        int unsigned x;
        int unsigned y;
        if (a >= 640 * 480) return 8'h00;
        x = a % 640;
        y = a / 640;
        if (x == 0 || x == 639 || y == 0 || y == 479) return 8'h92;
        for (int b = 0; b < 8; b++) begin
            if (x < (b + 1) * 80) begin
                case (b)
                    0: return 8'hFF;
                    1: return 8'hFC;
                    2: return 8'h1F;
                    3: return 8'h1C;
                    4: return 8'hE3;
                    5: return 8'hE0;
                    6: return 8'h03;
                    default: return 8'h00;
                endcase
            end
        end
        return 8'h00;
    endfunction

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic cyc(input logic r, input int unsigned a);
        rst  = r;
        addr = 19'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input int unsigned a,
                      input logic [7:0] exp);
        cyc(1'b1, a);
        check(tag, q, exp);
    endtask

    initial begin
        int unsigned a;
        logic        r;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        addr  = '0;
        @(negedge clk);

        cyc(1'b0, 641);
        check("reset_q", q, 8'h00);
        rd("reset_release", 641, 8'hFF);

        for (int i = 0; i < 700; i++) begin
            cyc(1'b1, i);
            check("stream", q, ref_pix(i));
            if (i == 0)   check("stream_a0", q, 8'h92);
            if (i == 641) check("stream_a641", q, 8'hFF);
        end

        rd("bar1", 720, 8'hFC);
        rd("bar2", 800, 8'h1F);
        rd("bar3", 880, 8'h1C);
        rd("bar4", 960, 8'hE3);
        rd("bar5", 1040, 8'hE0);
        rd("bar6", 1120, 8'h03);
        rd("bar7", 1200, 8'h00);
        rd("bar0_end", 719, 8'hFF);
        rd("bar7_end", 1278, 8'h00);

        rd("brd_top_right", 639, 8'h92);
        rd("brd_right", 64639, 8'h92);
        rd("brd_bottom_left", 306560, 8'h92);
        rd("brd_left", 64000, 8'h92);
        rd("brd_bottom_mid", 306900, 8'h92);
        rd("row478_x1", 478 * 640 + 1, 8'hFF);

        rd("last_pixel", 307199, 8'h92);
        rd("oor_first", 307200, 8'h00);
        rd("oor_last", 524287, 8'h00);
        rd("wrap_zero", 0, 8'h92);

        for (int i = 700; i < 705; i++) rd("pre_rst", i, ref_pix(i));
        cyc(1'b0, 705);
        check("mid_rst0", q, 8'h00);
        cyc(1'b0, 706);
        check("mid_rst1", q, 8'h00);
        rd("rst_exit", 1200, 8'h00);
        rd("rst_exit_next", 1041, 8'hE0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 524287);
                1: a = $urandom_range(0, 307199);
                2: a = $urandom_range(0, 479) * 640 + $urandom_range(0, 2) * 79
                       + $urandom_range(0, 1) * 1;
                default: a = $urandom_range(307190, 307210);
            endcase
            r = ($urandom_range(0, 31) != 0);
            cyc(r, a);
            check("random", q, r ? ref_pix(a) : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
